// File: rtl/image_loader.sv
// Image loader: buffers a 16-bit pixel stream and writes one frame to SDRAM over Avalon-MM,
// then hands the frame to the compute block. Define LOADER_CHECKSUM_EN to add a frame checksum.
module image_loader #(
  parameter int unsigned BASE_ADDR  = 600000,
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned ADDR_STEP  = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        waitrequest,
  output logic        chipselect,
  output logic [1:0]  byteenable,
  output logic        read_n,
  output logic        write_n,
  output logic [31:0] address,
  output logic [15:0] writedata,
  output logic        compute_ready,
  input  logic        compute_done,
  output logic        busy,
`ifdef LOADER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic [7:0]  frame_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned FC_W   = 8;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = ($clog2(NUM_PIXELS + 1) > 10) ? $clog2(NUM_PIXELS + 1) : 10;

  localparam logic [CNT_W-1:0] NUM_PIX  = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);
  localparam logic [OCC_W-1:0] DEPTH    = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HANDOFF,
    S_RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                write_n_q, write_n_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic                compute_ready_q, compute_ready_d;
  logic                busy_q, busy_d;
  logic [FC_W-1:0]     frame_count_q, frame_count_d;

  logic                in_ready_c;
  logic                push;
  logic                pop;
  logic [OCC_W-1:0]    avail;
  logic [DATA_W-1:0]   next_head;

  // Handshakes: accept only while filling with room and pixels still owed; pop on a completed write
  always_comb begin
    in_ready_c = (state_q == S_FILL) && (occ_q != DEPTH) && (acc_cnt_q < NUM_PIX);
    push       = in_valid && in_ready_c;
    pop        = !write_n_q && !waitrequest;
  end

  // Next state, FIFO bookkeeping and the registered Avalon write stage
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    occ_d           = occ_q + OCC_W'(push) - OCC_W'(pop);
    acc_cnt_d       = acc_cnt_q;
    wr_cnt_d        = wr_cnt_q;
    write_n_d       = 1'b1;
    address_d       = address_q;
    writedata_d     = writedata_q;
    frame_count_d   = frame_count_q;
    // Entries present next cycle, ignoring this cycle's push so a new pixel waits one edge
    avail           = occ_q - OCC_W'(pop);
    next_head       = pop ? mem_q[rd_ptr_q + PTR_W'(1)] : mem_q[rd_ptr_q];

    if (push) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FILL;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          occ_d     = '0;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
        end
      end
      S_FILL: begin
        if (pop && (wr_cnt_q == LAST_IDX)) state_d = S_HANDOFF;
      end
      S_HANDOFF: begin
        if (compute_done) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!compute_done) begin
          state_d       = S_IDLE;
          frame_count_d = frame_count_q + FC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!write_n_q && waitrequest) begin
      write_n_d = 1'b0;
    end else if ((state_q == S_FILL) && (state_d == S_FILL) && (avail != '0)) begin
      write_n_d   = 1'b0;
      writedata_d = next_head;
      address_d   = ADDR_W'(BASE_ADDR) + ADDR_W'(ADDR_STEP) * ADDR_W'(wr_cnt_d);
    end

    compute_ready_d = (state_d == S_HANDOFF);
    busy_d          = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      acc_cnt_q       <= '0;
      wr_cnt_q        <= '0;
      write_n_q       <= 1'b1;
      address_q       <= ADDR_W'(BASE_ADDR);
      writedata_q     <= '0;
      compute_ready_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      acc_cnt_q       <= acc_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      write_n_q       <= write_n_d;
      address_q       <= address_d;
      writedata_q     <= writedata_d;
      compute_ready_q <= compute_ready_d;
      busy_q          <= busy_d;
      frame_count_q   <= frame_count_d;
    end
  end

  // FIFO storage carries no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == S_IDLE) && start) checksum_d = '0;
    else if (pop)                     checksum_d = checksum_q + writedata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign in_ready      = in_ready_c;
  assign chipselect    = 1'b1;
  assign byteenable    = 2'b11;
  assign read_n        = 1'b1;
  assign write_n       = write_n_q;
  assign address       = address_q;
  assign writedata     = writedata_q;
  assign compute_ready = compute_ready_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: expected SDRAM writes are queued per frame and
// checked by an independent bus monitor.
module tb_image_loader;

  localparam int unsigned BASE  = 600000;
  localparam int unsigned NPIX  = 784;
  localparam int unsigned DEPTH = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        waitrequest;
  logic        chipselect;
  logic [1:0]  byteenable;
  logic        read_n;
  logic        write_n;
  logic [31:0] address;
  logic [15:0] writedata;
  logic        compute_ready;
  logic        compute_done;
  logic        busy;
  logic [7:0]  frame_count;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  image_loader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .waitrequest   (waitrequest),
    .chipselect    (chipselect),
    .byteenable    (byteenable),
    .read_n        (read_n),
    .write_n       (write_n),
    .address       (address),
    .writedata     (writedata),
    .compute_ready (compute_ready),
    .compute_done  (compute_done),
    .busy          (busy),
`ifdef LOADER_CHECKSUM_EN
    .checksum      (checksum),
`endif
    .frame_count   (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wr_t         exp_q[$];
  int          n_checks    = 0;
  int          n_pass      = 0;
  int          completions = 0;
  int          cr_rises    = 0;
  int          frame_rise0 = 0;
  int          occ         = 0;
  logic        prev_stall  = 1'b0;
  logic        prev_cr     = 1'b0;
  logic [31:0] prev_addr   = '0;
  logic [15:0] prev_data   = '0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [15:0] pix_val(input int mode, input int k);
    case (mode)
      0:       return 16'(k + 1);
      1:       return 16'hFFFF;
      default: return 16'd100;
    endcase
  endfunction

  // Bus monitor: samples mid-cycle, after the driver has settled this cycle's inputs
  always begin
    @(negedge clk);
    #2;
    if (!reset_n) begin
      prev_stall = 1'b0;
      prev_cr    = 1'b0;
      occ        = 0;
    end else begin
      if (prev_stall) begin
        chk(!write_n && (address == prev_addr), "stall_addr", address, prev_addr);
        chk(writedata == prev_data, "stall_data", 32'(writedata), 32'(prev_data));
      end
      if (!write_n && !waitrequest) begin
        completions++;
        chk(exp_q.size() != 0, "extra_write", address, 0);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk(address == e.addr, "wr_addr", address, e.addr);
          chk(writedata == e.data, "wr_data", 32'(writedata), 32'(e.data));
        end
      end
      if (occ >= int'(DEPTH)) chk(!in_ready, "in_ready_full", 32'(in_ready), 0);
      chk(occ <= int'(DEPTH), "fifo_overflow", occ, DEPTH);
      if (compute_ready && !prev_cr) cr_rises++;
      occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((!write_n && !waitrequest) ? 1 : 0);
      prev_stall = !write_n && waitrequest;
      prev_addr  = address;
      prev_data  = writedata;
      prev_cr    = compute_ready;
    end
  end

  // Drives one frame; reset_at >= 0 aborts with a 1-cycle reset once that many writes are done
  task automatic run_frame(input int mode, input int first_k, input bit rnd, input bit hold,
                           input int reset_at);
    int  k;
    int  comp0;
    int  cyc;
    bit  did_reset;
    wr_t e;
    k           = first_k;
    comp0       = completions;
    cyc         = 0;
    did_reset   = 1'b0;
    frame_rise0 = cr_rises;
    for (int i = 0; i < int'(NPIX); i++) begin
      e.addr = 32'(BASE + 2 * i);
      e.data = pix_val(mode, first_k + i);
      exp_q.push_back(e);
    end
    while (!compute_ready && (cyc < 20000) && !did_reset) begin
      @(negedge clk);
      start       = (cyc == 0);
      waitrequest = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if ((reset_at >= 0) && (completions - comp0 >= reset_at)) waitrequest = 1'b1;
      in_valid    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data     = pix_val(mode, k);
      #3;
      if (in_valid && in_ready) k++;
      if ((reset_at >= 0) && (completions - comp0 >= reset_at) && !write_n && waitrequest) begin
        chk(completions - comp0 == reset_at, "reset_wr_cnt", completions - comp0, reset_at);
        @(negedge clk);
        start    = 1'b0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n     = 1'b1;
        waitrequest = 1'b0;
        #3;
        chk(write_n == 1'b1, "rst_mid_write_n", 32'(write_n), 1);
        chk(busy == 1'b0, "rst_mid_busy", 32'(busy), 0);
        chk(in_ready == 1'b0, "rst_mid_in_ready", 32'(in_ready), 0);
        chk(address == BASE, "rst_mid_addr", address, BASE);
        chk(frame_count == 8'd0, "rst_mid_fc", 32'(frame_count), 0);
        exp_q.delete();
        did_reset = 1'b1;
      end
      cyc++;
    end
    start = 1'b0;
    if (!did_reset) begin
      chk(compute_ready, "frame_timeout", cyc, 20000);
      chk(completions - comp0 == int'(NPIX), "completions", completions - comp0, NPIX);
      chk(exp_q.size() == 0, "writes_missing", exp_q.size(), 0);
      chk(k - first_k == int'(NPIX), "accepted", k - first_k, NPIX);
      chk(write_n == 1'b1, "write_n_after_last", 32'(write_n), 1);
      if (hold) chk(!in_ready, "in_ready_surplus", 32'(in_ready), 0);
      else in_valid = 1'b0;
      waitrequest = 1'b0;
    end
  endtask

  // compute_done rises 5 cycles after compute_ready, stays high 3 cycles
  task automatic handoff(input int exp_fc, input bit hold);
    repeat (4) begin
      @(negedge clk);
      #3;
      chk(compute_ready, "cr_held", 32'(compute_ready), 1);
      if (hold) chk(!in_ready, "in_ready_handoff", 32'(in_ready), 0);
    end
    @(negedge clk);
    compute_done = 1'b1;
    #3;
    chk(compute_ready, "cr_before_done", 32'(compute_ready), 1);
    @(negedge clk);
    #3;
    chk(!compute_ready, "cr_drop", 32'(compute_ready), 0);
    chk(busy, "busy_release", 32'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    compute_done = 1'b0;
    #3;
    chk(busy, "busy_done_high", 32'(busy), 1);
    @(negedge clk);
    #3;
    chk(!busy, "idle_after_done", 32'(busy), 0);
    chk(frame_count == 8'(exp_fc), "frame_count", 32'(frame_count), exp_fc);
    chk(cr_rises - frame_rise0 == 1, "cr_rises", cr_rises - frame_rise0, 1);
    if (hold) chk(!in_ready, "in_ready_idle", 32'(in_ready), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    waitrequest  = 1'b0;
    compute_done = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk(in_ready == 1'b0, "rst_in_ready", 32'(in_ready), 0);
    chk(write_n == 1'b1, "rst_write_n", 32'(write_n), 1);
    chk(address == BASE, "rst_address", address, BASE);
    chk(writedata == 16'd0, "rst_writedata", 32'(writedata), 0);
    chk(compute_ready == 1'b0, "rst_compute_ready", 32'(compute_ready), 0);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 0);
    chk(frame_count == 8'd0, "rst_frame_count", 32'(frame_count), 0);
    chk(chipselect == 1'b1, "chipselect", 32'(chipselect), 1);
    chk(byteenable == 2'b11, "byteenable", 32'(byteenable), 3);
    chk(read_n == 1'b1, "read_n", 32'(read_n), 1);
    @(negedge clk);
    reset_n = 1'b1;

    run_frame(0, 0, 1'b0, 1'b0, -1);
    handoff(1, 1'b0);
    run_frame(1, 0, 1'b1, 1'b0, -1);
    handoff(2, 1'b0);
    run_frame(0, 0, 1'b0, 1'b1, -1);
    handoff(3, 1'b1);
    run_frame(0, int'(NPIX), 1'b0, 1'b0, 300);
    run_frame(2, 0, 1'b0, 1'b0, -1);
`ifdef LOADER_CHECKSUM_EN
    chk(checksum == 16'd12864, "checksum", 32'(checksum), 12864);
`endif
    handoff(1, 1'b0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
